// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU dispatcher.
//   - alu_op_e : 3-bit ALU opcode encoding
//   - instruction word field positions and widths
//   - state_e  : dispatcher FSM states
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  localparam int INSTR_W = 15;
  localparam int OP_W    = 3;
  localparam int REG_W   = 4;
  localparam int OP_MSB  = 14;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  // state   | meaning
  // IDLE    | ready for an instruction
  // EXEC    | operands held on the ALU, wait counter running
  // WB      | result written to rd, done pulsed
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 16 x N register file, r0 hardwired to zero.
// Ports:
//   clk, rst_n            clock, async active-low reset (clears all entries)
//   we, waddr, wdata      synchronous write port (writes to r0 dropped)
//   raddr_a/rdata_a       combinational read port A
//   raddr_b/rdata_b       combinational read port B
//   dbg_addr/dbg_data     combinational debug read port
module alu_regfile #(
  parameter int N = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [3:0]   waddr,
  input  logic [N-1:0] wdata,
  input  logic [3:0]   raddr_a,
  output logic [N-1:0] rdata_a,
  input  logic [3:0]   raddr_b,
  output logic [N-1:0] rdata_b,
  input  logic [3:0]   dbg_addr,
  output logic [N-1:0] dbg_data
);

  logic [N-1:0] mem [16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (we && (waddr != 4'd0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a  = (raddr_a  == 4'd0) ? '0 : mem[raddr_a];
  assign rdata_b  = (raddr_b  == 4'd0) ? '0 : mem[raddr_b];
  assign dbg_data = (dbg_addr == 4'd0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch: single-issue instruction dispatcher for an external ALU.
// Accepts one instruction at a time, reads operands from an internal
// 16 x N register file, holds them on the ALU for ALU_WAIT cycles, then
// writes the ALU result back to rd and pulses done.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   instr_valid/instr_ready    instruction handshake; instr = {op, rd, rs1, rs2}
//   alu_a, alu_b, alu_op       operands/opcode to the ALU (held between uses)
//   alu_result, alu_z          ALU result and zero flag, captured in WB
//   done                       one-cycle retire pulse
//   z_flag                     zero flag of the last retired instruction
//   err                        sticky divide-by-zero trap (only with
//                              ALU_DISPATCH_DIVZERO_TRAP_EN defined)
//   dbg_addr/dbg_data          debug register-file read
// Build option: ALU_DISPATCH_DIVZERO_TRAP_EN -- trap div-by-zero instead of
// writing all-ones.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int N        = 20,
  parameter int ALU_WAIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [N-1:0]       alu_a,
  output logic [N-1:0]       alu_b,
  output logic [OP_W-1:0]    alu_op,
  input  logic [N-1:0]       alu_result,
  input  logic               alu_z,
  output logic               done,
  output logic               z_flag,
`ifdef ALU_DISPATCH_DIVZERO_TRAP_EN
  output logic               err,
`endif
  input  logic [3:0]         dbg_addr,
  output logic [N-1:0]       dbg_data
);

  localparam logic [3:0] WAIT_INIT = 4'(ALU_WAIT - 1);

  state_e           state, state_nxt;
  logic [3:0]       wait_cnt;
  logic [REG_W-1:0] rd_q;
  logic [N-1:0]     rdata_a, rdata_b;
  logic             accept, div_zero, wb_we, z_upd;
  logic [N-1:0]     wb_data;

  assign instr_ready = (state == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign div_zero    = (alu_op == OP_DIV) && (alu_b == '0);

`ifdef ALU_DISPATCH_DIVZERO_TRAP_EN
  assign wb_we   = (state == ST_WB) && !div_zero;
  assign z_upd   = wb_we;
  assign wb_data = alu_result;
`else
  assign wb_we   = (state == ST_WB);
  assign z_upd   = wb_we;
  assign wb_data = div_zero ? '1 : alu_result;
`endif

  alu_regfile #(.N(N)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wb_we),
    .waddr    (rd_q),
    .wdata    (wb_data),
    .raddr_a  (instr[RS1_MSB:RS1_LSB]),
    .rdata_a  (rdata_a),
    .raddr_b  (instr[RS2_MSB:RS2_LSB]),
    .rdata_b  (rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (instr_valid) state_nxt = ST_EXEC;
      ST_EXEC: if (wait_cnt == 4'd0) state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      rd_q     <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      done     <= 1'b0;
      z_flag   <= 1'b0;
    end else begin
      state <= state_nxt;
      // done is registered on the EXEC->WB transition so it is high exactly
      // during the WB cycle.
      done  <= (state == ST_EXEC) && (wait_cnt == 4'd0);
      if (accept) begin
        rd_q     <= instr[RD_MSB:RD_LSB];
        alu_op   <= instr[OP_MSB:OP_LSB];
        alu_a    <= rdata_a;
        alu_b    <= rdata_b;
        wait_cnt <= WAIT_INIT;
      end else if ((state == ST_EXEC) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (z_upd) z_flag <= div_zero ? 1'b0 : alu_z;
    end
  end

`ifdef ALU_DISPATCH_DIVZERO_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              err <= 1'b0;
    else if ((state == ST_WB) && div_zero)   err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
module tb_alu_dispatch;
  import alu_pkg::*;

  localparam int N  = 20;
  localparam int W1 = 1;
  localparam int W2 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance 1: ALU_WAIT = 1
  logic               v1 = 1'b0, rdy1, done1, zf1, z1;
  logic [INSTR_W-1:0] instr1 = '0;
  logic [N-1:0]       a1, b1, res1, dbgd1;
  logic [2:0]         op1;
  logic [3:0]         dbga1 = '0;
  logic               ld1_en = 1'b0;
  logic [N-1:0]       ld1_val = '0;
  // instance 2: ALU_WAIT = 4
  logic               v2 = 1'b0, rdy2, done2, zf2, z2;
  logic [INSTR_W-1:0] instr2 = '0;
  logic [N-1:0]       a2, b2, res2, dbgd2;
  logic [2:0]         op2;
  logic [3:0]         dbga2 = '0;
  logic               ld2_en = 1'b0;
  logic [N-1:0]       ld2_val = '0;
`ifdef ALU_DISPATCH_DIVZERO_TRAP_EN
  logic               err1, err2;
`endif

  function automatic logic [N-1:0] alu_fn(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] r;
    case (op)
      3'b000: r = a + b;
      3'b001: r = a - b;
      3'b010: r = a * b;
      3'b011: r = (b == '0) ? N'(20'h12345) : a / b;
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a << b;
      default: r = a >> b;
    endcase
    return r;
  endfunction

  assign res1 = ld1_en ? ld1_val : alu_fn(op1, a1, b1);
  assign z1   = (res1 == '0);
  assign res2 = ld2_en ? ld2_val : alu_fn(op2, a2, b2);
  assign z2   = (res2 == '0);

  alu_dispatch #(.N(N), .ALU_WAIT(W1)) dut1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(v1), .instr_ready(rdy1), .instr(instr1),
    .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_result(res1), .alu_z(z1),
    .done(done1), .z_flag(zf1),
`ifdef ALU_DISPATCH_DIVZERO_TRAP_EN
    .err(err1),
`endif
    .dbg_addr(dbga1), .dbg_data(dbgd1)
  );

  alu_dispatch #(.N(N), .ALU_WAIT(W2)) dut2 (
    .clk(clk), .rst_n(rst_n), .instr_valid(v2), .instr_ready(rdy2), .instr(instr2),
    .alu_a(a2), .alu_b(b2), .alu_op(op2), .alu_result(res2), .alu_z(z2),
    .done(done2), .z_flag(zf2),
`ifdef ALU_DISPATCH_DIVZERO_TRAP_EN
    .err(err2),
`endif
    .dbg_addr(dbga2), .dbg_data(dbgd2)
  );

  typedef struct {
    logic [3:0]   rd;
    logic [N-1:0] oldv;
    logic [N-1:0] newv;
    logic         z;
    logic         errv;
  } exp_t;

  exp_t         sb[$];
  logic [N-1:0] mrf [16];
  logic         mz = 1'b0;
  logic         merr = 1'b0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; waits for ready, drives one instruction, pushes its
  // expected outcome and checks the latched operands just after acceptance.
  task automatic issue1(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
    int n = 0;
    exp_t e;
    logic [N-1:0] a, b, r;
    while (!rdy1 && n < 50) begin @(negedge clk); n++; end
    chk("issue_ready", 32'(rdy1), 1);
    v1 = 1'b1;
    instr1 = {op, rd, rs1, rs2};
    dbga1 = rd;
    a = mrf[rs1];
    b = mrf[rs2];
    r = ld1_en ? ld1_val : alu_fn(op, a, b);
    e.rd = rd;
    e.oldv = mrf[rd];
    e.z = (r == '0);
    e.errv = merr;
    e.newv = (rd == 4'd0) ? '0 : r;
`ifdef ALU_DISPATCH_DIVZERO_TRAP_EN
    if (op == OP_DIV && b == '0) begin
      e.newv = e.oldv;
      e.z = mz;
      e.errv = 1'b1;
    end
`else
    if (op == OP_DIV && b == '0) begin
      e.newv = (rd == 4'd0) ? '0 : '1;
      e.z = 1'b0;
    end
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    v1 = 1'b0;
    chk("alu_a", 32'(a1), 32'(a));
    chk("alu_b", 32'(b1), 32'(b));
    chk("alu_op", 32'(op1), 32'(op));
    chk("busy", 32'(rdy1), 0);
  endtask

  task automatic retire1();
    int n = 1;
    exp_t e;
    @(negedge clk);
    while (!done1 && n < 40) begin @(negedge clk); n++; end
    chk("latency", 32'(n), 32'(W1 + 1));
    chk("sb_nonempty", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("dbg_old", 32'(dbgd1), 32'(e.oldv));
      chk("ready_wb", 32'(rdy1), 0);
      @(negedge clk);
      chk("done_pulse", 32'(done1), 0);
      chk("dbg_new", 32'(dbgd1), 32'(e.newv));
      chk("z_flag", 32'(zf1), 32'(e.z));
      chk("ready_idle", 32'(rdy1), 1);
`ifdef ALU_DISPATCH_DIVZERO_TRAP_EN
      chk("err", 32'(err1), 32'(e.errv));
`endif
      if (e.rd != 4'd0) mrf[e.rd] = e.newv;
      mz = e.z;
      merr = e.errv;
    end
  endtask

  initial begin
    int n, accepts, dones, last_acc;
    for (int i = 0; i < 16; i++) mrf[i] = '0;
    dbga1 = 4'd3;
    #12;
    chk("rst_ready", 32'(rdy1), 1);
    chk("rst_done", 32'(done1), 0);
    chk("rst_z", 32'(zf1), 0);
    chk("rst_a", 32'(a1), 0);
    chk("rst_op", 32'(op1), 0);
    chk("rst_dbg", 32'(dbgd1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(rdy1), 1);

    // preload r1=7, r2=5, r6=3 through forced ALU results
    ld1_en = 1'b1;
    ld1_val = 20'd7; issue1(OP_ADD, 4'd1, 4'd0, 4'd0); retire1();
    ld1_val = 20'd5; issue1(OP_ADD, 4'd2, 4'd0, 4'd0); retire1();
    ld1_val = 20'd3; issue1(OP_ADD, 4'd6, 4'd0, 4'd0); retire1();
    ld1_en = 1'b0;

    issue1(OP_ADD, 4'd3, 4'd1, 4'd2); retire1();   // r3 = 12
    issue1(OP_SUB, 4'd4, 4'd1, 4'd1); retire1();   // r4 = 0, z = 1
    issue1(OP_ADD, 4'd5, 4'd4, 4'd2); retire1();   // r5 = 5
    issue1(OP_ADD, 4'd0, 4'd1, 4'd2); retire1();   // r0 stays 0
    issue1(OP_SHL, 4'd8, 4'd2, 4'd4); retire1();   // r8 = 5 << 0
    issue1(OP_OR,  4'd9, 4'd1, 4'd3); retire1();   // r9 = 7 | 12
    issue1(OP_DIV, 4'd6, 4'd1, 4'd0); retire1();   // divide by zero
    issue1(OP_DIV, 4'd10, 4'd3, 4'd2); retire1();  // 12 / 5 after the trap

    // reset during EXEC of mul r7,r1,r2
    issue1(OP_MUL, 4'd7, 4'd1, 4'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("abort_done", 32'(done1), 0);
    chk("abort_ready", 32'(rdy1), 1);
    chk("abort_a", 32'(a1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 16; i++) mrf[i] = '0;
    mz = 1'b0;
    merr = 1'b0;
    @(negedge clk);
    chk("abort_ready_rel", 32'(rdy1), 1);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (done1) n++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(n), 0);
    chk("abort_r7", 32'(dbgd1), 0);

    // ALU_WAIT=4 instance: preload r1=9, then hold instr_valid high
    ld2_en = 1'b1;
    ld2_val = 20'd9;
    dbga2 = 4'd1;
    v2 = 1'b1;
    instr2 = {OP_ADD, 4'd1, 4'd0, 4'd0};
    @(negedge clk);
    v2 = 1'b0;
    n = 0;
    while (!done2 && n < 40) begin @(negedge clk); n++; end
    chk("w4_latency", 32'(n), 32'(W2));
    @(negedge clk);
    ld2_en = 1'b0;
    chk("w4_preload", 32'(dbgd2), 9);
    dbga2 = 4'd2;
    v2 = 1'b1;
    instr2 = {OP_ADD, 4'd2, 4'd1, 4'd1};
    accepts = 0;
    dones = 0;
    last_acc = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (rdy2) begin
        accepts++;
        if (last_acc >= 0) chk("w4_gap", 32'(cyc - last_acc), 32'(W2 + 2));
        last_acc = cyc;
      end else if (!done2) begin
        chk("w4_exec_a", 32'(a2), 9);
        chk("w4_exec_b", 32'(b2), 9);
        chk("w4_exec_op", 32'(op2), 32'(OP_ADD));
      end
      if (done2) dones++;
      @(negedge clk);
    end
    v2 = 1'b0;
    chk("w4_accepts", 32'(accepts), 7);
    chk("w4_dones", 32'(dones), 6);
    repeat (3) @(negedge clk);
    chk("w4_r2", 32'(dbgd2), 18);
    chk("w4_z", 32'(zf2), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 Parameter N, default 20: ALU data width in bits.
REQ-002 Parameter ALU_WAIT, default 1, range 1..15: cycles the operands and opcode are held stable before the result is captured.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 instr_valid  input  1  instruction word offered.
REQ-006 instr_ready  output  1  dispatcher can accept an instruction.
REQ-007 instr  input  15  bit fields: [14:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2.
REQ-008 alu_a, alu_b  output  N each  operands to the ALU.
REQ-009 alu_op  output  3  ALU opcode: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 shl, 111 shr.
REQ-010 alu_result  input  N  ALU result.
REQ-011 alu_z  input  1  ALU zero flag.
REQ-012 done  output  1  one-cycle pulse when the instruction retires.
REQ-013 z_flag  output  1  registered alu_z of the last retired instruction.
REQ-014 dbg_addr  input  4  register-file debug read address.
REQ-015 dbg_data  output  N  combinational read of the addressed register; reads 0 for address 0.

Function
REQ-016 The block SHALL hold a 16 x N register file; r0 SHALL read as 0 and writes to r0 SHALL be discarded.
REQ-017 The FSM SHALL have states IDLE, EXEC and WB; instr_ready SHALL be 1 only in IDLE.
REQ-018 IDLE: when instr_valid and instr_ready are both 1 at edge T, the block SHALL latch op and rd, latch rf[rs1] into alu_a and rf[rs2] into alu_b, drive alu_op = op, and enter EXEC.
REQ-019 EXEC: alu_a, alu_b and alu_op SHALL stay constant; a wait counter SHALL count ALU_WAIT cycles, then the FSM SHALL enter WB.
REQ-020 WB: the block SHALL write alu_result to rd, load z_flag from alu_z, assert done for exactly one cycle, and return to IDLE.
REQ-021 Latency: done SHALL be high in cycle T+ALU_WAIT+1, and instr_ready SHALL return high at T+ALU_WAIT+2.
REQ-022 Operands SHALL be read at accept time, so an instruction whose source equals the previous rd SHALL see the written-back value; there are no hazards because at most one instruction is in flight.
REQ-023 While instr_ready is 0, instr_valid SHALL be ignored and the instr word SHALL NOT be sampled.
REQ-024 Outside EXEC, alu_a, alu_b and alu_op SHALL hold their last values; no glitching to zero.
REQ-025 A dbg_addr read of the same register written in a WB cycle SHALL return the old value in that cycle and the new value afterwards.

Reset
REQ-026 On rst_n low, the block SHALL asynchronously enter IDLE and clear the wait counter, alu_a, alu_b, alu_op (to 000), done, z_flag, err (if present) and every register-file entry to 0.
REQ-027 Reset asserted in EXEC or WB SHALL abort the instruction with no writeback and no done pulse.
REQ-028 After rst_n deasserts, instr_ready SHALL be 1 at the first rising edge.

Configuration
REQ-029 Macro ALU_DISPATCH_DIVZERO_TRAP_EN.
- Defined: adds output err (1 bit, sticky, cleared only by reset). A div (011) with alu_b == 0 SHALL still run through EXEC and WB and pulse done, but SHALL NOT write rd or update z_flag, and SHALL set err.
- Undefined: no err port; div by zero SHALL write all-ones to rd and set z_flag to 0.

Structure
REQ-030 A shared package alu_pkg SHALL hold the opcode enum (3 bits), the instruction field positions and widths, and the FSM state enum.
REQ-031 The register file SHALL be a sub-module alu_regfile: 16 x N, one synchronous write port, two combinational read ports plus a debug read port, r0 forced to zero.

Verification
REQ-032 Directed scenarios the bench SHALL cover:
- Reset, preload r1=7 and r2=5, issue add r3,r1,r2: done at T+2 with ALU_WAIT=1, dbg r3=12, z_flag=0.
- sub r4,r1,r1: r4=0, z_flag=1; back-to-back issue of add r5,r4,r2 gives r5=5.
- Write to r0: add r0,r1,r2 retires with done, and dbg r0 stays 0.
- div r6,r1,r0: with the trap defined, r6 is unchanged and err=1; without it, r6=0xFFFFF.
- ALU_WAIT=4 with instr_valid held high: exactly one accept every 6 cycles, and alu_a/alu_b are stable through EXEC.
- rst_n pulsed low in EXEC of mul r7,r1,r2: no done, r7=0, and instr_ready=1 after release.
